// File: rtl/uop_queue.sv
// Circular 16-entry microinstruction queue: accepts up to IN_UOP uops per cycle,
// issues one per cycle, and stamps each stored uop's color with its slot index.
package uop_queue_pkg;
   typedef logic [3:0] uop_index_t;

   typedef struct packed {
      logic [7:0] name;
      logic [4:0] dest;
      logic [4:0] src;
      uop_index_t color;
   } uop_ins_t;
endpackage

module uop_queue
   import uop_queue_pkg::*;
#(
   parameter int IN_UOP = 5,
   parameter int QU_UOP = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       flush,
   input  uop_ins_t   in_uops [IN_UOP],
   input  logic [2:0] in_count,
   output logic       in_accept,
   output logic [4:0] free_slots,
   output logic       out_valid,
   output uop_ins_t   out_uop,
   input  logic       out_ready
);

   uop_ins_t   r_storage [QU_UOP];
   uop_index_t r_head;
   uop_index_t r_tail;
   logic [4:0] r_count;

   logic [4:0] w_free;
   logic       w_push;
   logic       w_pop;
   uop_index_t w_slot     [IN_UOP];
   uop_ins_t   w_lane_uop [IN_UOP];

   // Free space comes only from the registered count; a same-cycle pop never helps a push.
   assign w_free     = 5'(QU_UOP) - r_count;
   assign free_slots = w_free;

   assign in_accept = reset_n && !flush && (in_count != 3'd0) &&
                      (in_count <= 3'(IN_UOP)) && ({2'b00, in_count} <= w_free);
   assign w_push    = in_accept;
   assign w_pop     = (r_count != 5'd0) && out_ready && !flush;

   assign out_valid = (r_count != 5'd0);
   assign out_uop   = r_storage[r_head];

   generate
      for (genvar gi = 0; gi < IN_UOP; gi++) begin : g_lane
         assign w_slot[gi]     = r_tail + uop_index_t'(gi);
         assign w_lane_uop[gi] = '{name:  in_uops[gi].name,
                                   dest:  in_uops[gi].dest,
                                   src:   in_uops[gi].src,
                                   color: w_slot[gi]};
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_tail <= r_tail + {1'b0, in_count};
         if (w_pop)
            r_head <= r_head + 4'd1;
         r_count <= r_count + (w_push ? {2'b00, in_count} : 5'd0) - (w_pop ? 5'd1 : 5'd0);
      end
   end

   // Storage carries no reset; entries are only meaningful between head and tail.
   always_ff @(posedge clk) begin
      for (int i = 0; i < IN_UOP; i++) begin
         if (w_push && (i < int'(in_count)))
            r_storage[w_slot[i]] <= w_lane_uop[i];
      end
   end

   always @(posedge clk) begin
      if (reset_n) begin
         assert (r_count <= 5'(QU_UOP));
         assert (uop_index_t'(r_tail - r_head) == r_count[3:0]);
         assert (!(in_accept && ({2'b00, in_count} > w_free)));
         assert (in_count <= 3'(IN_UOP));
      end
   end

endmodule

// File: tb/tb_uop_queue.sv
// Directed self-checking bench for uop_queue: push/pop, fill, wrap, flush, async reset.
module tb_uop_queue;
   import uop_queue_pkg::*;

   localparam int IN_UOP = 5;
   localparam int QU_UOP = 16;

   logic       clk;
   logic       reset_n;
   logic       flush;
   uop_ins_t   in_uops [IN_UOP];
   logic [2:0] in_count;
   logic       in_accept;
   logic [4:0] free_slots;
   logic       out_valid;
   uop_ins_t   out_uop;
   logic       out_ready;

   int checks;
   int failures;

   uop_queue #(.IN_UOP(IN_UOP), .QU_UOP(QU_UOP)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .in_uops    (in_uops),
      .in_count   (in_count),
      .in_accept  (in_accept),
      .free_slots (free_slots),
      .out_valid  (out_valid),
      .out_uop    (out_uop),
      .out_ready  (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Lane i carries name base+i, dest i+1, src i+2 and a junk color the queue must overwrite.
   task automatic set_grp(input int n, input logic [7:0] base);
      for (int i = 0; i < IN_UOP; i++) begin
         in_uops[i].name  = base + 8'(i);
         in_uops[i].dest  = 5'(i + 1);
         in_uops[i].src   = 5'(i + 2);
         in_uops[i].color = 4'hF - 4'(i);
      end
      in_count = 3'(n);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset_n   = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      set_grp(5, 8'h41);

      // reset state, with a legal group already presented
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_free", free_slots, 16);
      chk("rst_accept", in_accept, 0);
      tick();
      reset_n = 1'b1;
      settle();
      chk("push5_accept", in_accept, 1);
      chk("push5_no_bypass", out_valid, 0);
      tick();
      in_count = 3'd0;
      $display("push A..E: free=%0d valid=%0d name=%0h color=%0d", free_slots, out_valid, out_uop.name, out_uop.color);
      chk("push5_free", free_slots, 11);
      chk("push5_valid", out_valid, 1);
      chk("push5_name", out_uop.name, 8'h41);
      chk("push5_color", out_uop.color, 0);
      chk("push5_dest", out_uop.dest, 1);
      chk("push5_src", out_uop.src, 2);

      // pop A..E, colors 0..4
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         $display("pop k=%0d name=%0h color=%0d", k, out_uop.name, out_uop.color);
         chk("popAE_name", out_uop.name, 8'h41 + 8'(k));
         chk("popAE_color", out_uop.color, 32'(k));
         tick();
      end
      out_ready = 1'b0;
      chk("popAE_empty", out_valid, 0);
      chk("popAE_free", free_slots, 16);

      // fill: 5,5,5 accepted, 2 rejected, 1 accepted (head = tail = 5 at start)
      for (int g = 0; g < 3; g++) begin
         set_grp(5, 8'h50 + 8'(5 * g));
         settle();
         $display("fill group %0d accept=%0d free=%0d", g, in_accept, free_slots);
         chk("fill_accept", in_accept, 1);
         tick();
      end
      in_count = 3'd0;
      chk("fill_free1", free_slots, 1);
      set_grp(2, 8'h60);
      settle();
      chk("fill_reject2", in_accept, 0);
      tick();
      chk("fill_hold_free", free_slots, 1);
      set_grp(1, 8'h62);
      settle();
      chk("fill_accept1", in_accept, 1);
      tick();
      in_count = 3'd0;
      chk("full_free0", free_slots, 0);
      chk("full_valid", out_valid, 1);
      chk("full_head_color", out_uop.color, 5);
      chk("full_head_name", out_uop.name, 8'h50);
      set_grp(1, 8'h63);
      settle();
      chk("full_reject1", in_accept, 0);
      in_count = 3'd0;

      // pop 5 from full -> count 11, head 10
      out_ready = 1'b1;
      repeat (5) tick();
      out_ready = 1'b0;
      chk("c11_free", free_slots, 5);
      chk("c11_head_color", out_uop.color, 10);

      // simultaneous push of 5 and pop
      set_grp(5, 8'h70);
      out_ready = 1'b1;
      settle();
      chk("pushpop_accept", in_accept, 1);
      tick();
      in_count  = 3'd0;
      out_ready = 1'b0;
      $display("push+pop: free=%0d head_color=%0d", free_slots, out_uop.color);
      chk("pushpop_free", free_slots, 1);
      chk("pushpop_head_color", out_uop.color, 11);

      // drain 15 entries: colors 11..15,0..9
      out_ready = 1'b1;
      for (int k = 0; k < 15; k++) begin
         chk("drain_color", out_uop.color, 32'((11 + k) % 16));
         tick();
      end
      chk("drain_empty", out_valid, 0);

      // move head = tail from 10 to 14
      out_ready = 1'b0;
      set_grp(4, 8'h80);
      tick();
      in_count  = 3'd0;
      out_ready = 1'b1;
      repeat (4) tick();
      chk("pre_wrap_empty", out_valid, 0);
      chk("pre_wrap_free", free_slots, 16);

      // wrap: tail 14 + 4 writes slots 14,15,0,1
      out_ready = 1'b0;
      set_grp(4, 8'h90);
      tick();
      in_count  = 3'd0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         $display("wrap pop k=%0d name=%0h color=%0d", k, out_uop.name, out_uop.color);
         chk("wrap_valid", out_valid, 1);
         chk("wrap_color", out_uop.color, 32'((14 + k) % 16));
         chk("wrap_name", out_uop.name, 8'h90 + 8'(k));
         tick();
      end
      out_ready = 1'b0;
      chk("wrap_end_empty", out_valid, 0);
      chk("wrap_end_free", free_slots, 16);

      // flush at count 7 with a concurrent push of 3 and out_ready
      set_grp(5, 8'hA0);
      tick();
      set_grp(2, 8'hA5);
      tick();
      in_count = 3'd0;
      chk("pre_flush_free", free_slots, 9);
      set_grp(3, 8'hB0);
      out_ready = 1'b1;
      flush     = 1'b1;
      settle();
      chk("flush_accept", in_accept, 0);
      tick();
      flush     = 1'b0;
      in_count  = 3'd0;
      out_ready = 1'b0;
      $display("flush: valid=%0d free=%0d", out_valid, free_slots);
      chk("flush_valid", out_valid, 0);
      chk("flush_free", free_slots, 16);
      set_grp(1, 8'hC0);
      tick();
      in_count = 3'd0;
      chk("post_flush_color", out_uop.color, 0);
      chk("post_flush_name", out_uop.name, 8'hC0);
      chk("post_flush_free", free_slots, 15);

      // async reset mid-cycle at count 9
      set_grp(5, 8'hD0);
      tick();
      set_grp(3, 8'hD5);
      tick();
      in_count = 3'd0;
      chk("pre_rst_free", free_slots, 7);
      #2;
      reset_n = 1'b0;
      #1;
      $display("async reset: valid=%0d free=%0d", out_valid, free_slots);
      chk("arst_valid", out_valid, 0);
      chk("arst_free", free_slots, 16);
      #1;
      reset_n = 1'b1;
      set_grp(1, 8'hE0);
      settle();
      chk("post_rst_accept", in_accept, 1);
      tick();
      in_count = 3'd0;
      chk("post_rst_color", out_uop.color, 0);
      chk("post_rst_name", out_uop.name, 8'hE0);
      chk("post_rst_free", free_slots, 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
